// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory controller: I/O map defaults,
// FSM state encoding and register reset values.
package lc3_mem_ctrl_pkg;

    localparam logic [15:0] IO_BASE        = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR_DEF  = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEF  = 16'hFE02;
    localparam logic [15:0] DSR_ADDR_DEF   = 16'hFE04;
    localparam logic [15:0] DDR_ADDR_DEF   = 16'hFE06;
    localparam logic [15:0] MCR_ADDR_DEF   = 16'hFFFE;
    localparam logic [15:0] MCR_RESET      = 16'h8000;
    localparam int          TIMEOUT_DEF    = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IO,
        ST_M_REQ,
        ST_M_WAIT,
        ST_DONE
    } state_t;

    function automatic logic is_io(input logic [15:0] a);
        return a >= IO_BASE;
    endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// Memory-mapped I/O register file: keyboard status/data, display data,
// machine control, plus the read mux seen by the controller.
module lc3_io_regs
    import lc3_mem_ctrl_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF,
    parameter logic [15:0] MCR_ADDR  = MCR_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_char,
    input  logic        disp_rdy,
    output logic [15:0] rd_data,
    output logic        ddr_valid,
    output logic [7:0]  ddr_char,
    output logic        kb_irq,
    output logic        mcr_run
);

    logic        kb_ready;
    logic        kb_ie;
    logic [7:0]  kbdr;
    logic [7:0]  ddr_q;
    logic [15:0] mcr;

    logic io_wr;
    logic kbdr_rd;
    logic kb_take;

    assign io_wr   = io_sel & we;
    assign kbdr_rd = io_sel & ~we & (addr == KBDR_ADDR);
    // A KBDR read in the same cycle frees the slot, so the new key is taken.
    assign kb_take = kb_strobe & (~kb_ready | kbdr_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            kb_ready <= 1'b0;
            kb_ie    <= 1'b0;
            kbdr     <= 8'h00;
            ddr_q    <= 8'h00;
            mcr      <= MCR_RESET;
        end else begin
            if (kb_take) begin
                kbdr     <= kb_char;
                kb_ready <= 1'b1;
            end else if (kbdr_rd) begin
                kb_ready <= 1'b0;
            end
            if (io_wr && addr == KBSR_ADDR) kb_ie <= wdata[14];
            if (io_wr && addr == MCR_ADDR)  mcr   <= wdata;
            if (ddr_valid)                  ddr_q <= wdata[7:0];
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (addr == KBSR_ADDR)      rd_data = {kb_ready, kb_ie, 14'b0};
        else if (addr == KBDR_ADDR) rd_data = {8'h00, kbdr};
        else if (addr == DSR_ADDR)  rd_data = {disp_rdy, 15'b0};
        else if (addr == MCR_ADDR)  rd_data = mcr;
    end

    // The display sees the new character during the pulse itself.
    assign ddr_valid = io_wr & (addr == DDR_ADDR);
    assign ddr_char  = ddr_valid ? wdata[7:0] : ddr_q;
    assign kb_irq    = kb_ready & kb_ie;
    assign mcr_run   = mcr[15];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access controller: latches one request, serves memory-mapped
// I/O locally and forwards everything else to the 64Kx16 array.
module lc3_mem_ctrl
    import lc3_mem_ctrl_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
    parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
    parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF,
    parameter logic [15:0] MCR_ADDR  = MCR_ADDR_DEF,
    parameter int          TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [15:0] mem_a,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_r,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_char,
    input  logic        disp_rdy,
    output logic        ddr_valid,
    output logic [7:0]  ddr_char,
    output logic        kb_irq,
    output logic        mcr_run
);

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      addr_q;
    logic [15:0]      wdata_q;
    logic             we_q;
    logic [15:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      io_rdata;
    logic             accept;
    logic             io_sel;
    logic             timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        io_sel      = 1'b0;
        mem_en      = 1'b0;
        ready       = 1'b0;
        busy        = 1'b1;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = is_io(addr) ? ST_IO : ST_M_REQ;
                end
            end
            ST_IO: begin
                io_sel    = 1'b1;
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_M_REQ: begin
                mem_en    = 1'b1;
                state_nxt = ST_M_WAIT;
            end
            ST_M_WAIT: begin
                // A response on the final wait cycle still wins over the timeout.
                timeout_hit = ~mem_r & (wait_cnt == LAST_WAIT);
                if (mem_r || timeout_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
                err_q   <= 1'b0;
            end
            if (state == ST_M_REQ)       wait_cnt <= '0;
            else if (state == ST_M_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (io_sel) rdata_q <= io_rdata;
            if (state == ST_M_WAIT) begin
                if (mem_r) begin
                    rdata_q <= mem_dout;
                end else if (timeout_hit) begin
                    rdata_q <= 16'h0000;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign rdata   = io_sel ? io_rdata : rdata_q;
    assign err     = err_q;
    assign mem_rw  = we_q;
    assign mem_a   = addr_q;
    assign mem_din = wdata_q;

    lc3_io_regs #(
        .KBSR_ADDR (KBSR_ADDR),
        .KBDR_ADDR (KBDR_ADDR),
        .DSR_ADDR  (DSR_ADDR),
        .DDR_ADDR  (DDR_ADDR),
        .MCR_ADDR  (MCR_ADDR)
    ) u_io_regs (
        .clk       (clk),
        .rst       (rst),
        .io_sel    (io_sel),
        .we        (we_q),
        .addr      (addr_q),
        .wdata     (wdata_q),
        .kb_strobe (kb_strobe),
        .kb_char   (kb_char),
        .disp_rdy  (disp_rdy),
        .rd_data   (io_rdata),
        .ddr_valid (ddr_valid),
        .ddr_char  (ddr_char),
        .kb_irq    (kb_irq),
        .mcr_run   (mcr_run)
    );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: transaction-level model of latency, I/O
// registers and memory contents, checked against the DUT every cycle.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic        ready, busy, err;
    logic        mem_en, mem_rw;
    logic [15:0] mem_a, mem_din;
    logic [15:0] mem_dout = 16'h0;
    logic        mem_r = 1'b0;
    logic        kb_strobe = 1'b0;
    logic [7:0]  kb_char = 8'h0;
    logic        disp_rdy = 1'b0;
    logic        ddr_valid;
    logic [7:0]  ddr_char;
    logic        kb_irq, mcr_run;

    lc3_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_a(mem_a), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_r(mem_r),
        .kb_strobe(kb_strobe), .kb_char(kb_char), .disp_rdy(disp_rdy),
        .ddr_valid(ddr_valid), .ddr_char(ddr_char), .kb_irq(kb_irq), .mcr_run(mcr_run)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Array stand-in: registered, answers one cycle after mem_en, echoes writes.
    logic [15:0] arr [logic [15:0]];
    bit mem_resp_en = 1'b1;
    always @(posedge clk) begin
        mem_r <= 1'b0;
        if (mem_en && mem_resp_en) begin
            if (mem_rw) begin
                arr[mem_a] = mem_din;
                mem_dout <= mem_din;
            end else begin
                mem_dout <= arr.exists(mem_a) ? arr[mem_a] : 16'h0000;
            end
            mem_r <= 1'b1;
        end
    end

    // Reference model state.
    logic [15:0] m_mem [logic [15:0]];
    bit          m_kbr = 1'b0, m_ie = 1'b0;
    logic [7:0]  m_kbdr = 8'h0, m_ddr_char = 8'h0;
    logic [15:0] m_mcr = 16'h8000;

    // Current access as predicted by the model.
    bit          chk_en = 1'b0;
    bit          acc_active = 1'b0, acc_mem = 1'b0, acc_read = 1'b0, acc_ddr = 1'b0;
    bit          acc_we = 1'b0, acc_err = 1'b0;
    int          acc_n = 0, acc_rdy = 0;
    logic [15:0] acc_addr = 16'h0, acc_wdata = 16'h0, acc_rdata = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] io_read(input logic [15:0] a);
        if (a == 16'hFE00) return {m_kbr, m_ie, 14'b0};
        if (a == 16'hFE02) return {8'h00, m_kbdr};
        if (a == 16'hFE04) return {disp_rdy, 15'b0};
        if (a == 16'hFFFE) return m_mcr;
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_busy, e_ready, e_mem_en, e_ddr;
            e_busy   = acc_active && cyc >= acc_n && cyc <= acc_rdy;
            e_ready  = acc_active && cyc == acc_rdy;
            e_mem_en = acc_active && acc_mem && cyc == acc_n;
            e_ddr    = acc_active && acc_ddr && cyc == acc_n;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ready", 32'(ready), 32'(e_ready));
            chk("mem_en", 32'(mem_en), 32'(e_mem_en));
            chk("ddr_valid", 32'(ddr_valid), 32'(e_ddr));
            chk("ddr_char", 32'(ddr_char), 32'(m_ddr_char));
            chk("kb_irq", 32'(kb_irq), 32'(m_kbr & m_ie));
            chk("mcr_run", 32'(mcr_run), 32'(m_mcr[15]));
            if (e_mem_en) begin
                chk("mem_a", 32'(mem_a), 32'(acc_addr));
                chk("mem_rw", 32'(mem_rw), 32'(acc_we));
                chk("mem_din", 32'(mem_din), 32'(acc_wdata));
            end
            if (e_ready) begin
                chk("err", 32'(err), 32'(acc_err));
                if (acc_read) chk("rdata", 32'(rdata), 32'(acc_rdata));
            end
        end
    end

    task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                          input bit resp, input bit strb, input logic [7:0] sc,
                          output logic [15:0] got_d, output logic got_e);
        bit io, kbdr_rd, kb_acc;
        @(negedge clk);
        io          = (a >= 16'hFE00);
        mem_resp_en = resp;
        acc_mem     = !io;
        acc_read    = !w;
        acc_we      = w;
        acc_addr    = a;
        acc_wdata   = d;
        acc_ddr     = io && w && a == 16'hFE06;
        acc_err     = !io && !resp;
        if (io)         acc_rdata = io_read(a);
        else if (!resp) acc_rdata = 16'h0000;
        else            acc_rdata = m_mem.exists(a) ? m_mem[a] : 16'h0000;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req        = 1'b0;
        acc_n      = cyc;
        acc_rdy    = cyc + (io ? 0 : (resp ? 2 : 16));
        acc_active = 1'b1;
        if (acc_ddr) m_ddr_char = d[7:0];
        if (strb) begin
            kb_strobe = 1'b1;
            kb_char   = sc;
        end
        repeat (acc_rdy - acc_n) @(posedge clk);
        @(negedge clk);
        got_d = rdata;
        got_e = err;
        @(posedge clk);
        #1;
        kb_strobe  = 1'b0;
        kbdr_rd    = io && !w && a == 16'hFE02;
        kb_acc     = strb && (!m_kbr || kbdr_rd);
        if (kbdr_rd) m_kbr = 1'b0;
        if (kb_acc) begin
            m_kbdr = sc;
            m_kbr  = 1'b1;
        end
        if (io && w && a == 16'hFE00) m_ie = d[14];
        if (io && w && a == 16'hFFFE) m_mcr = d;
        if (!io && w && resp) m_mem[a] = d;
        acc_active = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] c);
        @(negedge clk);
        kb_strobe = 1'b1;
        kb_char   = c;
        @(posedge clk);
        #1;
        kb_strobe = 1'b0;
        if (!m_kbr) begin
            m_kbdr = c;
            m_kbr  = 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_a", 32'(mem_a), 32'h0);
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_ddr_valid", 32'(ddr_valid), 32'h0);
        chk("rst_mcr_run", 32'(mcr_run), 32'h1);
        chk("rst_kb_irq", 32'(kb_irq), 32'h0);
        rst    = 1'b0;
        chk_en = 1'b1;

        access(1, 16'h3000, 16'hBEEF, 1, 0, 8'h0, d, e);
        access(0, 16'h3000, 16'h0000, 1, 0, 8'h0, d, e);
        chk("raw_x3000", 32'(d), 32'hBEEF);
        chk("raw_err", 32'(e), 32'h0);
        access(1, 16'h3001, 16'h1234, 1, 0, 8'h0, d, e);
        access(0, 16'h3001, 16'h0000, 1, 0, 8'h0, d, e);
        chk("raw_x3001", 32'(d), 32'h1234);
        access(0, 16'hFDFF, 16'h0000, 1, 0, 8'h0, d, e);

        access(0, 16'h4000, 16'h0000, 0, 0, 8'h0, d, e);
        chk("timeout_rdata", 32'(d), 32'h0);
        chk("timeout_err", 32'(e), 32'h1);

        strobe(8'h41);
        access(0, 16'hFE00, 16'h0, 1, 0, 8'h0, d, e);
        chk("kbsr_full", 32'(d), 32'h8000);
        access(0, 16'hFE02, 16'h0, 1, 0, 8'h0, d, e);
        chk("kbdr_a", 32'(d), 32'h0041);
        access(0, 16'hFE00, 16'h0, 1, 0, 8'h0, d, e);
        chk("kbsr_empty", 32'(d), 32'h0000);

        access(1, 16'hFE00, 16'h4000, 1, 0, 8'h0, d, e);
        strobe(8'h41);
        @(negedge clk);
        chk("kb_irq_set", 32'(kb_irq), 32'h1);
        strobe(8'h42);
        access(0, 16'hFE02, 16'h0, 1, 0, 8'h0, d, e);
        chk("kbdr_keep", 32'(d), 32'h0041);

        strobe(8'h50);
        access(0, 16'hFE02, 16'h0, 1, 1, 8'h51, d, e);
        chk("kbdr_race_old", 32'(d), 32'h0050);
        access(0, 16'hFE02, 16'h0, 1, 0, 8'h0, d, e);
        chk("kbdr_race_new", 32'(d), 32'h0051);

        disp_rdy = 1'b1;
        access(0, 16'hFE04, 16'h0, 1, 0, 8'h0, d, e);
        chk("dsr_rdy", 32'(d), 32'h8000);
        disp_rdy = 1'b0;
        access(0, 16'hFE04, 16'h0, 1, 0, 8'h0, d, e);
        chk("dsr_busy", 32'(d), 32'h0000);
        access(1, 16'hFE04, 16'hFFFF, 1, 0, 8'h0, d, e);

        access(1, 16'hFE06, 16'h0163, 1, 0, 8'h0, d, e);
        chk("ddr_char_lit", 32'(ddr_char), 32'h63);
        access(1, 16'hFE08, 16'hAAAA, 1, 0, 8'h0, d, e);
        access(0, 16'hFE08, 16'h0, 1, 0, 8'h0, d, e);
        chk("unmapped_io", 32'(d), 32'h0000);

        access(1, 16'hFFFE, 16'h0000, 1, 0, 8'h0, d, e);
        @(negedge clk);
        chk("mcr_run_off", 32'(mcr_run), 32'h0);
        access(0, 16'hFFFE, 16'h0, 1, 0, 8'h0, d, e);
        chk("mcr_read", 32'(d), 32'h0000);

        @(negedge clk);
        chk_en      = 1'b0;
        mem_resp_en = 1'b0;
        req = 1'b1; we = 1'b0; addr = 16'h5000;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(ready), 32'h0);
        chk("midrst_mcr_run", 32'(mcr_run), 32'h1);
        chk("midrst_mem_en", 32'(mem_en), 32'h0);
        m_kbr = 1'b0; m_ie = 1'b0; m_kbdr = 8'h0; m_ddr_char = 8'h0; m_mcr = 16'h8000;
        chk_en = 1'b1;
        access(0, 16'hFFFE, 16'h0, 1, 0, 8'h0, d, e);
        chk("mcr_after_rst", 32'(d), 32'h8000);
        access(0, 16'h3000, 16'h0, 1, 0, 8'h0, d, e);
        chk("x3000_after_rst", 32'(d), 32'hBEEF);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
